random_piece_source: RTL and testbench

- Parametrised Galois LFSR random source with a bounded-range output stage. Delivers uniformly distributed values 0..range_p-1, e.g. the seven Tetris piece IDs, to a consumer over a valid/ready handshake.
- Adds features the plain LFSR generator lacks: runtime seed load, zero-seed lock-up protection, rejection sampling with bounded latency, optional single reroll of an immediate repeat, and a reject statistic.
- Sits between the game controller (seed from a free-running counter at game start) and the piece-spawn logic.

---
 rtl/random_piece_source.sv | 156 +++++++++++++++
 tb/tb_random_piece_source.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/random_piece_source.sv
// Galois LFSR random source with a bounded-range output stage.
// Delivers values 0..range_p-1 (e.g. Tetris piece IDs) to a consumer.
// Candidates come from the low bits of the LFSR. Out-of-range candidates are
// rejected, and so is one immediate repeat of the last delivered value. After
// max_reject_p consecutive rejects the next candidate is folded into range,
// which bounds the latency of every draw.
//
// Handshake: valid_o/data_o form a standard valid/ready source. A value
// transfers on any rising clk_i edge where valid_o && ready_i. While
// valid_o && !ready_i, data_o holds steady. A transfer cycle may capture the
// next value at the same edge, which gives one value per cycle. seed_v_i drops
// any value that has not been taken.
module random_piece_source #(
  parameter int unsigned          width_p         = 32,
  parameter logic [width_p-1:0]   mask_p          = width_p'(32'h0040_0006),
  parameter logic [width_p-1:0]   seed_p          = width_p'(38),
  parameter int unsigned          range_p         = 7,
  parameter int unsigned          max_reject_p    = 3,
  parameter bit                   reroll_repeat_p = 1'b1,
  localparam int unsigned         out_width_lp    = $clog2(range_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    seed_v_i,
  input  logic [width_p-1:0]      seed_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [out_width_lp-1:0] data_o,
  output logic [width_p-1:0]      lfsr_o,
  output logic [7:0]              reject_cnt_o
);

  // A zero state would lock the LFSR, so a zero seed is replaced by 1.
  localparam logic [width_p-1:0] reset_seed_lp =
    (seed_p == '0) ? width_p'(1) : seed_p;

  localparam int unsigned streak_w_lp = $clog2(max_reject_p + 2);
  localparam logic [streak_w_lp-1:0]  max_rej_lp  = streak_w_lp'(max_reject_p);
  localparam logic [out_width_lp:0]   range_lp    = (out_width_lp + 1)'(range_p);
  localparam logic [out_width_lp-1:0] range_lo_lp = out_width_lp'(range_p);

  logic [width_p-1:0]      lfsr_q, lfsr_d, lfsr_step;
  logic                    valid_q, valid_d;
  logic [out_width_lp-1:0] data_q, data_d;
  logic [out_width_lp-1:0] last_q, last_d;
  logic                    has_last_q, has_last_d;
  logic [streak_w_lp-1:0]  streak_q, streak_d;
  logic                    rerolled_q, rerolled_d;
  logic [7:0]              reject_cnt_q, reject_cnt_d;

  logic [out_width_lp-1:0] cand;
  logic [out_width_lp:0]   cand_ext;
  logic [out_width_lp-1:0] accept_val;
  logic                    capture, do_accept, do_reject;

  // One Galois step: the MSB feeds bit 0 and XORs into every tapped bit.
  always_comb begin
    lfsr_step    = '0;
    lfsr_step[0] = lfsr_q[width_p-1];
    for (int i = 1; i < int'(width_p); i++) begin
      lfsr_step[i] = lfsr_q[i-1] ^ (mask_p[i] & lfsr_q[width_p-1]);
    end
  end

  // Seed load, candidate decision and delivery bookkeeping.
  always_comb begin
    lfsr_d       = lfsr_step;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    has_last_d   = has_last_q;
    streak_d     = streak_q;
    rerolled_d   = rerolled_q;
    reject_cnt_d = reject_cnt_q;
    cand         = lfsr_q[out_width_lp-1:0];
    cand_ext     = {1'b0, cand};
    accept_val   = cand;
    capture      = 1'b0;
    do_accept    = 1'b0;
    do_reject    = 1'b0;

    if (seed_v_i) begin
      lfsr_d       = (seed_i == '0) ? width_p'(1) : seed_i;
      valid_d      = 1'b0;
      has_last_d   = 1'b0;
      streak_d     = '0;
      rerolled_d   = 1'b0;
      reject_cnt_d = '0;
    end else begin
      capture = !valid_q || ready_i;
    end

    if (capture) begin
      if (streak_q == max_rej_lp) begin
        // Forced accept: cand < 2*range_p, so one subtraction brings it in range.
        do_accept = 1'b1;
        if (cand_ext >= range_lp) begin
          accept_val = cand - range_lo_lp;
        end
      end else if (cand_ext >= range_lp) begin
        do_reject = 1'b1;
      end else if (reroll_repeat_p && has_last_q && (cand == last_q) && !rerolled_q) begin
        do_reject  = 1'b1;
        rerolled_d = 1'b1;
      end else begin
        do_accept = 1'b1;
      end
    end

    if (do_accept) begin
      data_d     = accept_val;
      valid_d    = 1'b1;
      last_d     = accept_val;
      has_last_d = 1'b1;
      streak_d   = '0;
      rerolled_d = 1'b0;
    end

    if (do_reject) begin
      valid_d  = 1'b0;
      streak_d = streak_q + streak_w_lp'(1);
      if (reject_cnt_q != 8'hFF) begin
        reject_cnt_d = reject_cnt_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_q       <= reset_seed_lp;
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= '0;
      has_last_q   <= 1'b0;
      streak_q     <= '0;
      rerolled_q   <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      has_last_q   <= has_last_d;
      streak_q     <= streak_d;
      rerolled_q   <= rerolled_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign lfsr_o       = lfsr_q;
  assign reject_cnt_o = reject_cnt_q;

endmodule

// File: tb/tb_random_piece_source.sv
// Directed bench for random_piece_source using a 4-bit LFSR (mask 4'b0011,
// seed 1, range 7). u_dut allows 3 rejects per draw; u_dut0 allows none and
// always folds. Both instances share every input.
module tb_random_piece_source;

  logic       clk;
  logic       reset_n;
  logic       seed_v;
  logic [3:0] seed;
  logic       ready;

  logic       valid, valid0;
  logic [2:0] data, data0;
  logic [3:0] lfsr, lfsr0;
  logic [7:0] cnt, cnt0;

  int tests;
  int fails;

  // Period-15 state sequence starting from state 1.
  int seq [15] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9};

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_data;
    logic [3:0] exp_lfsr;
    logic [7:0] exp_cnt;
    logic [2:0] exp0_data;
  } vec_t;

  vec_t tbl [17];

  random_piece_source #(
    .width_p(4), .mask_p(4'b0011), .seed_p(4'd1), .range_p(7),
    .max_reject_p(3), .reroll_repeat_p(1'b1)
  ) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .seed_v_i(seed_v), .seed_i(seed),
    .ready_i(ready), .valid_o(valid), .data_o(data), .lfsr_o(lfsr),
    .reject_cnt_o(cnt)
  );

  random_piece_source #(
    .width_p(4), .mask_p(4'b0011), .seed_p(4'd1), .range_p(7),
    .max_reject_p(0), .reroll_repeat_p(1'b1)
  ) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .seed_v_i(seed_v), .seed_i(seed),
    .ready_i(ready), .valid_o(valid0), .data_o(data0), .lfsr_o(lfsr0),
    .reject_cnt_o(cnt0)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both duts between edges and check the reset state before any edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_lfsr", lfsr, 1);
    check("rst_cnt", cnt, 0);
    check("rst_valid0", valid0, 0);
    check("rst_lfsr0", lfsr0, 1);
    #3 reset_n = 1'b1;
  endtask

  // Free-running stream from reset release, one table row per edge.
  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) begin
      ready = tbl[i].ready;
      step();
      check($sformatf("%s_valid[%0d]", tag, i), valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("%s_data[%0d]", tag, i), data, tbl[i].exp_data);
      check($sformatf("%s_lfsr[%0d]", tag, i), lfsr, tbl[i].exp_lfsr);
      check($sformatf("%s_cnt[%0d]", tag, i), cnt, tbl[i].exp_cnt);
      check($sformatf("%s_valid0[%0d]", tag, i), valid0, 1);
      check($sformatf("%s_data0[%0d]", tag, i), data0, tbl[i].exp0_data);
      check($sformatf("%s_lfsr0[%0d]", tag, i), lfsr0, tbl[i].exp_lfsr);
      check($sformatf("%s_cnt0[%0d]", tag, i), cnt0, 0);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    seed_v  = 1'b0;
    seed    = 4'd0;
    ready   = 1'b1;

    //            ready valid data lfsr cnt data0
    tbl[0]  = '{1'b1, 1'b1, 3'd1, 4'd2,  8'd0, 3'd1};
    tbl[1]  = '{1'b1, 1'b1, 3'd2, 4'd4,  8'd0, 3'd2};
    tbl[2]  = '{1'b1, 1'b1, 3'd4, 4'd8,  8'd0, 3'd4};
    tbl[3]  = '{1'b1, 1'b1, 3'd0, 4'd3,  8'd0, 3'd0};
    tbl[4]  = '{1'b1, 1'b1, 3'd3, 4'd6,  8'd0, 3'd3};
    tbl[5]  = '{1'b1, 1'b1, 3'd6, 4'd12, 8'd0, 3'd6};
    tbl[6]  = '{1'b1, 1'b1, 3'd4, 4'd11, 8'd0, 3'd4};
    tbl[7]  = '{1'b1, 1'b1, 3'd3, 4'd5,  8'd0, 3'd3};
    tbl[8]  = '{1'b1, 1'b1, 3'd5, 4'd10, 8'd0, 3'd5};
    tbl[9]  = '{1'b1, 1'b1, 3'd2, 4'd7,  8'd0, 3'd2};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 4'd14, 8'd1, 3'd0};
    tbl[11] = '{1'b1, 1'b1, 3'd6, 4'd15, 8'd1, 3'd6};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 4'd13, 8'd2, 3'd0};
    tbl[13] = '{1'b1, 1'b1, 3'd5, 4'd9,  8'd2, 3'd5};
    tbl[14] = '{1'b1, 1'b1, 3'd1, 4'd1,  8'd2, 3'd1};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 4'd2,  8'd3, 3'd1};
    tbl[16] = '{1'b1, 1'b1, 3'd2, 4'd4,  8'd3, 3'd2};

    step();
    async_reset();
    run_table("run1");

    // Seed 0 while a value is offered: lock-up guard, offer dropped, stats cleared.
    seed_v = 1'b1;
    seed   = 4'd0;
    step();
    seed_v = 1'b0;
    check("seed_lfsr", lfsr, 1);
    check("seed_valid", valid, 0);
    check("seed_cnt", cnt, 0);
    step();
    check("seed_first_valid", valid, 1);
    check("seed_first_data", data, 1);
    check("seed_first_lfsr", lfsr, 2);

    // Stall until the state is 9 so the next capture repeats the last value (1).
    ready = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("stall13_valid[%0d]", k), valid, 1);
      check($sformatf("stall13_data[%0d]", k), data, 1);
      check($sformatf("stall13_lfsr[%0d]", k), lfsr, seq[1 + k]);
    end
    ready = 1'b1;
    step();
    check("repeat_rej_valid", valid, 0);
    check("repeat_rej_cnt", cnt, 1);
    check("repeat_rej_lfsr", lfsr, 1);
    step();
    check("reroll_valid", valid, 1);
    check("reroll_data", data, 1);
    check("reroll_lfsr", lfsr, 2);
    check("reroll_cnt", cnt, 1);

    // Five-cycle stall: data held, LFSR keeps stepping; release captures from state 12.
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("stall5_valid[%0d]", k), valid, 1);
      check($sformatf("stall5_data[%0d]", k), data, 1);
      check($sformatf("stall5_lfsr[%0d]", k), lfsr, seq[1 + k]);
    end
    ready = 1'b1;
    step();
    check("stall5_next_valid", valid, 1);
    check("stall5_next_data", data, 4);
    check("stall5_next_lfsr", lfsr, 11);
    check("stall5_next_cnt", cnt, 1);

    // Mid-stream asynchronous reset, then the stream must restart identically.
    async_reset();
    run_table("run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
